// File: rtl/falu_wb_buffer_pkg.sv
// Shared widths and entry layout helpers for the FP ALU writeback buffer.
// Defaults here are the system-wide datapath widths used by every instance.
package falu_wb_buffer_pkg;

  localparam int DEFAULT_XLEN               = 64;
  localparam int DEFAULT_ROB_INDEX_WIDTH    = 6;
  localparam int DEFAULT_PHY_REG_ADDR_WIDTH = 7;
  localparam int DEFAULT_FALU_WB_DEPTH      = 4;

  localparam int FFLAGS_W = 5;

  typedef logic [FFLAGS_W-1:0] fflags_t;

  // Bits per stored result: data, prd, rob, fflags, fflags_valid, float.
  function automatic int entry_width(input int xlen, input int phy_w, input int rob_w);
    return xlen + phy_w + rob_w + FFLAGS_W + 2;
  endfunction

endpackage

// File: rtl/falu_wb_fifo_mem.sv
// Result storage: one synchronous write port, one asynchronous read port.
// Write lands on the rising edge; read data follows raddr combinationally.
module falu_wb_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/falu_wb_buffer.sv
// FP ALU writeback buffer: in-order FIFO, 1-cycle min latency, head fields straight from storage.
// Backpressure: issue_ready from registered count only; a push into a full buffer without pop is dropped and flagged.
module falu_wb_buffer
  import falu_wb_buffer_pkg::*;
#(
  parameter int XLEN               = DEFAULT_XLEN,
  parameter int ROB_INDEX_WIDTH    = DEFAULT_ROB_INDEX_WIDTH,
  parameter int PHY_REG_ADDR_WIDTH = DEFAULT_PHY_REG_ADDR_WIDTH,
  parameter int FALU_WB_DEPTH      = DEFAULT_FALU_WB_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          trap,
  input  logic                          wfi,
  input  logic                          falu_resp_valid_i,
  input  logic [PHY_REG_ADDR_WIDTH-1:0] falu_prd_addr_i,
  input  logic [ROB_INDEX_WIDTH-1:0]    falu_rob_index_i,
  input  logic [XLEN-1:0]               falu_result_i,
  input  logic [FFLAGS_W-1:0]           falu_fflags_i,
  input  logic                          falu_fflags_valid_i,
  input  logic                          falu_resp_float_i,
  output logic                          falu_issue_ready_o,
  output logic                          wb_valid_o,
  input  logic                          wb_ready_i,
  output logic [PHY_REG_ADDR_WIDTH-1:0] wb_prd_addr_o,
  output logic [ROB_INDEX_WIDTH-1:0]    wb_rob_index_o,
  output logic [XLEN-1:0]               wb_result_o,
  output logic [FFLAGS_W-1:0]           wb_fflags_o,
  output logic                          wb_fflags_valid_o,
  output logic                          wb_float_o,
  output logic [FFLAGS_W-1:0]           acc_fflags_o,
  input  logic                          fflags_clr_i,
  output logic                          overflow_o
);

  localparam int PTR_W   = $clog2(FALU_WB_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = entry_width(XLEN, PHY_REG_ADDR_WIDTH, ROB_INDEX_WIDTH);

  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;
  fflags_t            acc_next;

  assign full  = (count == CNT_W'(FALU_WB_DEPTH));
  assign empty = (count == '0);

  assign falu_issue_ready_o = (count < CNT_W'(FALU_WB_DEPTH));
  assign wb_valid_o         = !empty && !wfi && !trap;
  assign pop                = wb_valid_o && wb_ready_i;
  // A pop in the same cycle frees the slot, so a full buffer can still take a result.
  assign push               = falu_resp_valid_i && !trap && (!full || pop);

  assign wr_entry = {falu_result_i, falu_prd_addr_i, falu_rob_index_i,
                     falu_fflags_i, falu_fflags_valid_i, falu_resp_float_i};

  assign {wb_result_o, wb_prd_addr_o, wb_rob_index_o,
          wb_fflags_o, wb_fflags_valid_o, wb_float_o} = rd_entry;

  falu_wb_fifo_mem #(
    .DEPTH (FALU_WB_DEPTH),
    .WIDTH (ENTRY_W),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push && !rst),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (rst || trap) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Clear first, then merge the retiring entry, so a clear never loses a same-cycle pop.
  always_comb begin
    acc_next = fflags_clr_i ? '0 : acc_fflags_o;
    if (pop && wb_fflags_valid_o) begin
      acc_next = acc_next | wb_fflags_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_fflags_o <= '0;
      overflow_o   <= 1'b0;
    end else begin
      acc_fflags_o <= acc_next;
      if (falu_resp_valid_i && !trap && full && !pop) begin
        overflow_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_falu_wb_buffer.sv
// Directed and randomized bench for falu_wb_buffer against a queue-based reference model.
module tb_falu_wb_buffer;
  import falu_wb_buffer_pkg::*;

  localparam int XL = DEFAULT_XLEN;
  localparam int RW = DEFAULT_ROB_INDEX_WIDTH;
  localparam int PW = DEFAULT_PHY_REG_ADDR_WIDTH;
  localparam int D  = DEFAULT_FALU_WB_DEPTH;

  logic          clk;
  logic          rst;
  logic          trap;
  logic          wfi;
  logic          falu_resp_valid_i;
  logic [PW-1:0] falu_prd_addr_i;
  logic [RW-1:0] falu_rob_index_i;
  logic [XL-1:0] falu_result_i;
  logic [4:0]    falu_fflags_i;
  logic          falu_fflags_valid_i;
  logic          falu_resp_float_i;
  logic          falu_issue_ready_o;
  logic          wb_valid_o;
  logic          wb_ready_i;
  logic [PW-1:0] wb_prd_addr_o;
  logic [RW-1:0] wb_rob_index_o;
  logic [XL-1:0] wb_result_o;
  logic [4:0]    wb_fflags_o;
  logic          wb_fflags_valid_o;
  logic          wb_float_o;
  logic [4:0]    acc_fflags_o;
  logic          fflags_clr_i;
  logic          overflow_o;

  falu_wb_buffer dut (
    .clk                 (clk),
    .rst                 (rst),
    .trap                (trap),
    .wfi                 (wfi),
    .falu_resp_valid_i   (falu_resp_valid_i),
    .falu_prd_addr_i     (falu_prd_addr_i),
    .falu_rob_index_i    (falu_rob_index_i),
    .falu_result_i       (falu_result_i),
    .falu_fflags_i       (falu_fflags_i),
    .falu_fflags_valid_i (falu_fflags_valid_i),
    .falu_resp_float_i   (falu_resp_float_i),
    .falu_issue_ready_o  (falu_issue_ready_o),
    .wb_valid_o          (wb_valid_o),
    .wb_ready_i          (wb_ready_i),
    .wb_prd_addr_o       (wb_prd_addr_o),
    .wb_rob_index_o      (wb_rob_index_o),
    .wb_result_o         (wb_result_o),
    .wb_fflags_o         (wb_fflags_o),
    .wb_fflags_valid_o   (wb_fflags_valid_o),
    .wb_float_o          (wb_float_o),
    .acc_fflags_o        (acc_fflags_o),
    .fflags_clr_i        (fflags_clr_i),
    .overflow_o          (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [XL-1:0] result;
    logic [PW-1:0] prd;
    logic [RW-1:0] rob;
    logic [4:0]    ff;
    logic          fv;
    logic          flt;
  } ent_t;

  ent_t       q[$];
  logic [4:0] m_acc;
  logic       m_ovf;
  int         compared;
  int         mismatched;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic v, input int rob, input logic [4:0] ff, input logic fv);
    falu_resp_valid_i   = v;
    falu_rob_index_i    = RW'(rob);
    falu_prd_addr_i     = PW'($urandom);
    falu_result_i       = {$urandom, $urandom};
    falu_fflags_i       = ff;
    falu_fflags_valid_i = fv;
    falu_resp_float_i   = 1'($urandom_range(0, 1));
  endtask

  // Check outputs against the model for the current inputs, then advance one clock.
  task automatic tick();
    logic exp_valid;
    logic do_pop;
    ent_t in_e;
    ent_t h;
    #1;
    exp_valid = (q.size() > 0) && !wfi && !trap;
    if (!rst) begin
      check("wb_valid", 64'(wb_valid_o), 64'(exp_valid));
      check("issue_ready", 64'(falu_issue_ready_o), 64'(q.size() < D));
      check("overflow", 64'(overflow_o), 64'(m_ovf));
      check("acc_fflags", 64'(acc_fflags_o), 64'(m_acc));
      if (exp_valid) begin
        h = q[0];
        check("head_rob", 64'(wb_rob_index_o), 64'(h.rob));
        check("head_prd", 64'(wb_prd_addr_o), 64'(h.prd));
        check("head_result", wb_result_o, h.result);
        check("head_fflags", 64'(wb_fflags_o), 64'(h.ff));
        check("head_fv", 64'(wb_fflags_valid_o), 64'(h.fv));
        check("head_float", 64'(wb_float_o), 64'(h.flt));
      end
    end
    in_e.result = falu_result_i;
    in_e.prd    = falu_prd_addr_i;
    in_e.rob    = falu_rob_index_i;
    in_e.ff     = falu_fflags_i;
    in_e.fv     = falu_fflags_valid_i;
    in_e.flt    = falu_resp_float_i;
    if (rst) begin
      q.delete();
      m_acc = '0;
      m_ovf = 1'b0;
    end else begin
      do_pop = exp_valid && wb_ready_i;
      if (fflags_clr_i) m_acc = '0;
      if (do_pop && q[0].fv) m_acc = m_acc | q[0].ff;
      if (trap) begin
        q.delete();
      end else begin
        if (falu_resp_valid_i && q.size() == D && !do_pop) m_ovf = 1'b1;
        if (do_pop) void'(q.pop_front());
        if (falu_resp_valid_i && q.size() < D) q.push_back(in_e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    set_in(1'b0, 0, 5'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    m_acc      = '0;
    m_ovf      = 1'b0;
    rst = 1'b1; trap = 1'b0; wfi = 1'b0; wb_ready_i = 1'b0; fflags_clr_i = 1'b0;
    idle_in();
    tick();
    tick();
    rst = 1'b0;
    tick();

    // In-order drain of three results.
    for (int i = 1; i <= 3; i++) begin
      set_in(1'b1, i, 5'($urandom), 1'b0);
      tick();
    end
    idle_in();
    wb_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // Full buffer with simultaneous push and pop.
    wb_ready_i = 1'b0;
    for (int i = 4; i <= 7; i++) begin
      set_in(1'b1, i, 5'b0, 1'b0);
      tick();
    end
    idle_in();
    tick();
    set_in(1'b1, 8, 5'b0, 1'b0);
    wb_ready_i = 1'b1;
    tick();
    idle_in();
    wb_ready_i = 1'b0;
    tick();
    check("no_overflow_on_push_pop", 64'(overflow_o), 64'd0);
    wb_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // Push into a full buffer is dropped and sticks the overflow flag.
    wb_ready_i = 1'b0;
    for (int i = 9; i <= 13; i++) begin
      set_in(1'b1, i, 5'b0, 1'b0);
      tick();
    end
    idle_in();
    wb_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("overflow_sticky", 64'(overflow_o), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Trap with a concurrent valid input flushes everything.
    wb_ready_i = 1'b0;
    for (int i = 14; i <= 15; i++) begin
      set_in(1'b1, i, 5'b0, 1'b0);
      tick();
    end
    set_in(1'b1, 16, 5'b0, 1'b0);
    trap = 1'b1;
    tick();
    trap = 1'b0;
    idle_in();
    tick();
    check("trap_flush_valid", 64'(wb_valid_o), 64'd0);
    check("trap_flush_ready", 64'(falu_issue_ready_o), 64'd1);

    // Flag accumulation and clear-with-pop.
    set_in(1'b1, 17, 5'b00001, 1'b1);
    tick();
    set_in(1'b1, 18, 5'b10000, 1'b1);
    tick();
    idle_in();
    wb_ready_i = 1'b1;
    tick();
    tick();
    check("acc_or", 64'(acc_fflags_o), 64'h11);
    wb_ready_i = 1'b0;
    set_in(1'b1, 19, 5'b00100, 1'b1);
    tick();
    idle_in();
    wb_ready_i = 1'b1;
    fflags_clr_i = 1'b1;
    tick();
    fflags_clr_i = 1'b0;
    check("acc_clr_with_pop", 64'(acc_fflags_o), 64'h04);

    // wfi stalls the drain but not the fill.
    wfi = 1'b1;
    for (int i = 20; i <= 21; i++) begin
      set_in(1'b1, i, 5'b0, 1'b0);
      tick();
    end
    idle_in();
    tick();
    tick();
    check("wfi_holds_valid", 64'(wb_valid_o), 64'd0);
    wfi = 1'b0;
    for (int i = 0; i < 3; i++) tick();

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      rst          = ($urandom_range(0, 299) == 0);
      trap         = ($urandom_range(0, 29) == 0);
      wfi          = ($urandom_range(0, 9) == 0);
      fflags_clr_i = ($urandom_range(0, 14) == 0);
      wb_ready_i   = ($urandom_range(0, 2) != 0);
      set_in(1'($urandom_range(0, 1)), int'($urandom_range(0, 63)), 5'($urandom), 1'($urandom_range(0, 1)));
      tick();
    end

    rst = 1'b0; trap = 1'b0; wfi = 1'b0; fflags_clr_i = 1'b0;
    idle_in();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
